// File: rtl/psdsqrt_seqctrl.sv
// Start/stop sequencer for the psdsqrt iterative square-root core: latches the
// operand, pulses start, waits out the iterations, pulses stop and captures the root.
module psdsqrt_seqctrl #(
  parameter int NBITSIN = 32,
  parameter int K       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NBITSIN+K-1:0]   xin_req,
  input  logic                   abort,
  output logic                   busy,
  output logic                   start,
  output logic                   stop,
  output logic [NBITSIN+K-1:0]   xin,
  input  logic [NBITSIN/2-1:0]   sqrt_in,
  output logic [NBITSIN/2-1:0]   result,
  output logic                   done,
  output logic [15:0]            opcount
);

  localparam int NCYCLES = (NBITSIN + K) / 2;
  localparam int CW      = $clog2(NCYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_STOP, S_LOAD, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NBITSIN+K-1:0]   xin_q, xin_d;
  logic [NBITSIN/2-1:0]   result_q, result_d;
  logic [15:0]            opcount_q, opcount_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      xin_q     <= '0;
      result_q  <= '0;
      opcount_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      xin_q     <= xin_d;
      result_q  <= result_d;
      opcount_q <= opcount_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xin_d     = xin_q;
    result_d  = result_q;
    opcount_d = opcount_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          xin_d   = xin_req;
          state_d = S_START;
        end
      end
      S_START: begin
        if (abort) state_d = S_IDLE;
        else begin
          cnt_d   = CW'(NCYCLES - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort)             state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_STOP;
        else                   cnt_d   = cnt_q - CW'(1);
      end
      S_STOP: state_d = abort ? S_IDLE : S_LOAD;
      S_LOAD: begin
        if (abort) state_d = S_IDLE;
        else begin
          // opcount moves with result so both are valid alongside done
          result_d  = sqrt_in;
          opcount_d = opcount_q + 16'd1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register: glitch-free, no input paths.
  assign busy    = (state_q != S_IDLE);
  assign start   = (state_q == S_START);
  assign stop    = (state_q == S_STOP);
  assign done    = (state_q == S_DONE);
  assign xin     = xin_q;
  assign result  = result_q;
  assign opcount = opcount_q;

endmodule

// File: tb/tb_psdsqrt_seqctrl.sv
// Randomized scoreboard bench for psdsqrt_seqctrl with a behavioural stub core
// that loads floor(sqrt(integer part of xin)) when stop pulses.
module tb_psdsqrt_seqctrl;

  localparam int NBITSIN = 32;
  localparam int K       = 8;
  localparam int W       = NBITSIN + K;
  localparam int NCYCLES = W / 2;

  logic                 clock, reset, run, abort;
  logic [W-1:0]         xin_req, xin;
  logic                 busy, start, stop, done;
  logic [NBITSIN/2-1:0] sqrt_in, result, core_q;
  logic [15:0]          opcount;

  psdsqrt_seqctrl #(.NBITSIN(NBITSIN), .K(K)) dut (
    .clock(clock), .reset(reset), .run(run), .xin_req(xin_req), .abort(abort),
    .busy(busy), .start(start), .stop(stop), .xin(xin), .sqrt_in(sqrt_in),
    .result(result), .done(done), .opcount(opcount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] res;
    logic [15:0] cnt;
    int          n0;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          op_n0 = -100;
  int          op_end = -100;
  logic [W-1:0] op_x = '0;
  logic [15:0] nops = '0;
  logic [15:0] held_res = '0;
  logic [15:0] held_cnt = '0;
  bit          exp_b;

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ((32'(t) * 32'(t)) <= v) r = t;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Stub core: output register loads on the stop edge.
  always @(posedge clock or negedge reset) begin
    if (!reset)    core_q <= '0;
    else if (stop) core_q <= isqrt(xin[W-1:K]);
  end
  assign sqrt_in = core_q;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: protocol shape every cycle, scoreboard pop on done.
  always @(negedge clock) begin
    if (!reset) begin
      held_res = '0;
      held_cnt = '0;
    end else begin
      exp_b = (cyc >= op_n0) && (cyc <= op_end);
      chk("busy",  busy,  exp_b);
      chk("start", start, exp_b && (cyc == op_n0));
      chk("stop",  stop,  exp_b && (cyc == op_n0 + NCYCLES + 1));
      if (exp_b) chk("xin_held", xin, op_x);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected act=1 exp=0 cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("result",  result, e.res);
          chk("opcount", opcount, e.cnt);
          chk("latency", cyc - e.n0, NCYCLES + 3);
          held_res = e.res;
          held_cnt = e.cnt;
        end
      end
      chk("result_hold",  result,  held_res);
      chk("opcount_hold", opcount, held_cnt);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One operation; ab_k/rst_k >= 0 inject abort / async reset in cycle k after issue.
  task automatic do_op(input logic [W-1:0] x, input bit ab_with_run,
                       input int ab_k, input int rst_k);
    run = 1'b1; abort = ab_with_run; xin_req = x;
    tick();
    run = 1'b0; abort = 1'b0;
    op_n0 = cyc; op_x = x; op_end = cyc + NCYCLES + 3;
    if (ab_k < 0 && rst_k < 0) begin
      nops = nops + 16'd1;
      sb.push_back('{isqrt(x[W-1:K]), nops, cyc});
    end
    for (int k = 0; k <= NCYCLES + 3; k++) begin
      xin_req = W'({$urandom(), $urandom()});
      run     = 1'($urandom_range(0, 1));
      abort   = (k == NCYCLES + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == rst_k) begin
        #1 reset = 1'b0;
        #1;
        chk("rst_busy",    busy,    0);
        chk("rst_start",   start,   0);
        chk("rst_stop",    stop,    0);
        chk("rst_done",    done,    0);
        chk("rst_result",  result,  0);
        chk("rst_opcount", opcount, 0);
        op_end = op_n0 - 1;
        nops   = '0;
        @(posedge clock);
        #1;
        reset = 1'b1; run = 1'b0; abort = 1'b0;
        return;
      end
      if (k == ab_k) begin
        abort  = 1'b1;
        op_end = op_n0 + k;
        tick();
        abort = 1'b0; run = 1'b0;
        return;
      end
      tick();
    end
    run = 1'b0; abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0;
      abort = 1'($urandom_range(0, 3) == 0);
      xin_req = W'({$urandom(), $urandom()});
      tick();
    end
    abort = 1'b0;
  endtask

  initial begin
    logic [W-1:0] x;
    reset = 1'b0; run = 1'b0; abort = 1'b0; xin_req = '0;
    tick(); tick();
    reset = 1'b1;
    idle(10);
    // 123456 in the integer field -> root 351; run and abort together
    x = W'(123456) << K;
    do_op(x, 1'b1, -1, -1);
    do_op(W'({$urandom(), $urandom()}), 1'b0, 5, -1);
    do_op(W'({$urandom(), $urandom()}), 1'b0, -1, -1);
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 3));
      x = W'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0)
        do_op(x, 1'($urandom_range(0, 1)), $urandom_range(0, NCYCLES + 2), -1);
      else
        do_op(x, 1'($urandom_range(0, 1)), -1, -1);
    end
    do_op(W'({$urandom(), $urandom()}), 1'b0, -1, 3);
    idle(30);
    do_op(W'({$urandom(), $urandom()}), 1'b0, -1, -1);
    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
